// File: rtl/frame_mem_arbiter_if.sv
// Bus bundle between the frame memory arbiter and its environment: display
// read port, buffered writer port, single-port memory port and status.
interface frame_mem_arbiter_if #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STALL_W    = 16
);

  // Display read port
  logic                            disp_rd;
  logic [ADDR_W-1:0]               disp_addr;
  logic [DATA_W-1:0]               disp_data;
  logic                            disp_valid;

  // Writer port
  logic                            wr_valid;
  logic                            wr_ready;
  logic [ADDR_W-1:0]               wr_addr;
  logic [DATA_W-1:0]               wr_data;

  // Frame memory port
  logic                            mem_en;
  logic                            mem_we;
  logic [ADDR_W-1:0]               mem_addr;
  logic [DATA_W-1:0]               mem_wdata;
  logic [DATA_W-1:0]               mem_rdata;

  // Status
  logic [$clog2(FIFO_DEPTH):0]     fifo_level;
  logic [STALL_W-1:0]              wr_stall_cnt;

  // Environment side: display, writer and memory model
  modport master (
    output disp_rd, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
    input  fifo_level, wr_stall_cnt
  );

  // Arbiter side
  modport slave (
    input  disp_rd, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_data, disp_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
    output fifo_level, wr_stall_cnt
  );

endinterface

// File: rtl/frame_mem_arbiter.sv
// Shares one single-port frame memory between a display reader with absolute
// priority and a writer buffered through a small FIFO. Writes drain only in
// cycles without a display read; read data returns with a fixed latency of 3.
module frame_mem_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STALL_W    = 16
) (
  input logic               clk,
  input logic               rstn,
  frame_mem_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]   LvlFull  = LVL_W'(FIFO_DEPTH);
  localparam logic [STALL_W-1:0] StallMax = '1;

  logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [STALL_W-1:0] stall_q;

  logic               mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;

  logic               rd_p1_q, rd_p2_q;
  logic               disp_valid_q;
  logic [DATA_W-1:0]  disp_data_q;

  logic               wr_ready;
  logic               push, pop;

  // Ready depends only on the registered level, so a pop never frees a slot
  // for the same cycle; gated by rstn so it reads 0 while held in reset.
  assign wr_ready = rstn && (level_q < LvlFull);
  assign push     = bus.wr_valid && wr_ready;
  assign pop      = (level_q != '0) && !bus.disp_rd;

  // FIFO storage; contents are don't-care until pushed, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= bus.wr_addr;
      fifo_data[wr_ptr_q] <= bus.wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Memory port: display read wins, otherwise drain one buffered write
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (bus.disp_rd) begin
      mem_en_q   <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= bus.disp_addr;
    end else if (pop) begin
      mem_en_q    <= 1'b1;
      mem_we_q    <= 1'b1;
      mem_addr_q  <= fifo_addr[rd_ptr_q];
      mem_wdata_q <= fifo_data[rd_ptr_q];
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end
  end

  // Read return pipeline: issue, memory latency, capture
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_p1_q      <= 1'b0;
      rd_p2_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_p1_q      <= bus.disp_rd;
      rd_p2_q      <= rd_p1_q;
      disp_valid_q <= rd_p2_q;
      if (rd_p2_q) disp_data_q <= bus.mem_rdata;
    end
  end

  // Saturating count of cycles the writer was held off
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (bus.wr_valid && !wr_ready && (stall_q != StallMax)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.disp_valid   = disp_valid_q;
  assign bus.disp_data    = disp_data_q;
  assign bus.fifo_level   = level_q;
  assign bus.wr_stall_cnt = stall_q;

endmodule
